// File: rtl/plot_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : plot_scheduler_if
// Purpose  : Pixel request/ack bundle for the three requesters, the clear
//            request, and the VGA write port, move tick and busy flag.
// Revision : 1.0 - initial release
// ============================================================================
interface plot_scheduler_if;
  logic       clear_req;

  logic       ball_req;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic [2:0] ball_colour;
  logic       ball_ack;

  logic       p1_req;
  logic [7:0] p1_x;
  logic [6:0] p1_y;
  logic [2:0] p1_colour;
  logic       p1_ack;

  logic       p2_req;
  logic [7:0] p2_x;
  logic [6:0] p2_y;
  logic [2:0] p2_colour;
  logic       p2_ack;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       move_tick;
  logic       busy;

  // Game/movement side: raises requests, watches acks and pacing
  modport master (
    output clear_req,
    output ball_req, ball_x, ball_y, ball_colour,
    output p1_req, p1_x, p1_y, p1_colour,
    output p2_req, p2_x, p2_y, p2_colour,
    input  ball_ack, p1_ack, p2_ack,
    input  vga_x, vga_y, vga_colour, vga_plot, move_tick, busy
  );

  // Scheduler side
  modport slave (
    input  clear_req,
    input  ball_req, ball_x, ball_y, ball_colour,
    input  p1_req, p1_x, p1_y, p1_colour,
    input  p2_req, p2_x, p2_y, p2_colour,
    output ball_ack, p1_ack, p2_ack,
    output vga_x, vga_y, vga_colour, vga_plot, move_tick, busy
  );
endinterface
`default_nettype wire

// File: rtl/plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : plot_scheduler
// Purpose  : Shares the VGA adapter pixel write port between ball, paddle 1
//            and paddle 2; sweeps a full-screen clear after reset or on
//            request; generates the movement pacing tick.
// Options  : PLOT_FIXED_PRIORITY_EN - fixed priority ball > p1 > p2 instead
//            of round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module plot_scheduler #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter int unsigned FRAME_DIV    = 833333,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic            clk,
  input  logic            resetn,
  plot_scheduler_if.slave bus
);

  localparam int unsigned c_CNT_W = $clog2(FRAME_DIV);
  localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(FRAME_DIV - 1);
  localparam logic [7:0] c_X_LAST = 8'(SCREEN_W - 1);
  // Row index one past the last row marks "sweep finished"
  localparam logic [6:0] c_Y_DONE = 7'(SCREEN_H);
  localparam logic [8:0] c_W_LIM  = 9'(SCREEN_W);
  localparam logic [7:0] c_H_LIM  = 8'(SCREEN_H);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t             r_state;
  logic [7:0]         r_cx;
  logic [6:0]         r_cy;
  logic [7:0]         r_vga_x;
  logic [6:0]         r_vga_y;
  logic [2:0]         r_vga_colour;
  logic               r_plot;
  logic [2:0]         r_ack;       // bit0 ball, bit1 p1, bit2 p2
  logic               r_busy;
  logic [c_CNT_W-1:0] r_frame_cnt;
  logic               r_tick;
`ifdef PLOT_FIXED_PRIORITY_EN
`else
  logic [2:0]         r_rr;        // one-hot: requester the search starts at
`endif

  logic [2:0] w_elig;
  logic [2:0] w_gnt_oh;
  logic       w_gnt_valid;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_colour;
  logic       w_in_range;

  // A requester being acked this cycle still shows its old data, so skip it
  assign w_elig = {bus.p2_req   & ~r_ack[2],
                   bus.p1_req   & ~r_ack[1],
                   bus.ball_req & ~r_ack[0]};
  assign w_gnt_valid = |w_elig;

  // Pick one eligible requester
  always_comb begin
    w_gnt_oh = 3'b000;
`ifdef PLOT_FIXED_PRIORITY_EN
    if (w_elig[0])      w_gnt_oh = 3'b001;
    else if (w_elig[1]) w_gnt_oh = 3'b010;
    else if (w_elig[2]) w_gnt_oh = 3'b100;
`else
    case (r_rr)
      3'b010: begin
        if (w_elig[1])      w_gnt_oh = 3'b010;
        else if (w_elig[2]) w_gnt_oh = 3'b100;
        else if (w_elig[0]) w_gnt_oh = 3'b001;
      end
      3'b100: begin
        if (w_elig[2])      w_gnt_oh = 3'b100;
        else if (w_elig[0]) w_gnt_oh = 3'b001;
        else if (w_elig[1]) w_gnt_oh = 3'b010;
      end
      default: begin
        if (w_elig[0])      w_gnt_oh = 3'b001;
        else if (w_elig[1]) w_gnt_oh = 3'b010;
        else if (w_elig[2]) w_gnt_oh = 3'b100;
      end
    endcase
`endif
  end

  // Route the winner's pixel toward the output registers
  always_comb begin
    w_sel_x      = bus.ball_x;
    w_sel_y      = bus.ball_y;
    w_sel_colour = bus.ball_colour;
    if (w_gnt_oh[1]) begin
      w_sel_x      = bus.p1_x;
      w_sel_y      = bus.p1_y;
      w_sel_colour = bus.p1_colour;
    end else if (w_gnt_oh[2]) begin
      w_sel_x      = bus.p2_x;
      w_sel_y      = bus.p2_y;
      w_sel_colour = bus.p2_colour;
    end
  end

  assign w_in_range = ({1'b0, w_sel_x} < c_W_LIM) && ({1'b0, w_sel_y} < c_H_LIM);

  // Clear sweep / serve state machine with registered VGA port and acks
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_CLEAR;
      r_cx         <= 8'd0;
      r_cy         <= 7'd0;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 3'd0;
      r_plot       <= 1'b0;
      r_ack        <= 3'b000;
      r_busy       <= 1'b1;
`ifdef PLOT_FIXED_PRIORITY_EN
`else
      r_rr         <= 3'b001;
`endif
    end else begin
      r_ack <= 3'b000;
      case (r_state)
        ST_CLEAR: begin
          if (r_cy == c_Y_DONE) begin
            r_state <= ST_SERVE;
            r_busy  <= 1'b0;
            r_plot  <= 1'b0;
            r_cy    <= 7'd0;
          end else begin
            r_vga_x      <= r_cx;
            r_vga_y      <= r_cy;
            r_vga_colour <= CLEAR_COLOUR;
            r_plot       <= 1'b1;
            if (r_cx == c_X_LAST) begin
              r_cx <= 8'd0;
              r_cy <= r_cy + 7'd1;
            end else begin
              r_cx <= r_cx + 8'd1;
            end
          end
        end
        default: begin
          if (bus.clear_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_plot  <= 1'b0;
            r_cx    <= 8'd0;
            r_cy    <= 7'd0;
          end else if (w_gnt_valid) begin
            r_vga_x      <= w_sel_x;
            r_vga_y      <= w_sel_y;
            r_vga_colour <= w_sel_colour;
            r_plot       <= w_in_range;
            r_ack        <= w_gnt_oh;
`ifdef PLOT_FIXED_PRIORITY_EN
`else
            r_rr         <= {w_gnt_oh[1:0], w_gnt_oh[2]};
`endif
          end else begin
            r_plot <= 1'b0;
          end
        end
      endcase
    end
  end

  // Frame pacing counter, held at zero whenever a clear is running or starting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
      r_tick      <= 1'b0;
    end else if (r_state == ST_CLEAR || bus.clear_req) begin
      r_frame_cnt <= '0;
      r_tick      <= 1'b0;
    end else if (r_frame_cnt == c_FRAME_LAST) begin
      r_frame_cnt <= '0;
      r_tick      <= 1'b1;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
      r_tick      <= 1'b0;
    end
  end

  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_plot;
  assign bus.ball_ack   = r_ack[0];
  assign bus.p1_ack     = r_ack[1];
  assign bus.p2_ack     = r_ack[2];
  assign bus.move_tick  = r_tick;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire
